// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: PC/ROM side toward program counter and instruction ROM,
// plus the valid/ready instruction handoff toward decode.
// The master modport is the fetch stage; the slave modport is its environment.
interface instruction_fetch_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_increment;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  flush;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic                  instr_valid;
  logic                  instr_ready;

  modport master (
    input  pc, rom_data, flush, instr_ready,
    output pc_increment, rom_addr, instr, instr_addr, instr_valid
  );

  modport slave (
    output pc, rom_data, flush, instr_ready,
    input  pc_increment, rom_addr, instr, instr_addr, instr_valid
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: addresses the synchronous ROM with the current PC,
// pulses the PC increment for every fetch issued, buffers returned words in a
// DEPTH-entry FIFO and hands them to decode tagged with their address.
// A flush drops everything buffered or in flight; fetching restarts at the
// newly loaded PC on the following cycle.
// Optional macro IFETCH_STATS_EN adds a saturating 16-bit bubble_cycles
// counter (decode ready but nothing valid).
module instruction_fetch #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  instruction_fetch_if.master    bus
`ifdef IFETCH_STATS_EN
  ,
  output logic [15:0]            bubble_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  // Wide enough for count + inflight, i.e. up to DEPTH + 1.
  localparam int CNT_W = $clog2(DEPTH + 2) + 1;

  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_addr;

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [CNT_W-1:0]      w_occ;

  // Handshake and issue decisions; a fetch is only issued if its return is
  // guaranteed a FIFO slot after accounting for this cycle's pop.
  always_comb begin
    w_valid = (r_count != '0) && !bus.flush;
    w_pop   = w_valid && bus.instr_ready;
    w_push  = r_inflight && !bus.flush;
    w_occ   = r_count + CNT_W'(r_inflight) - CNT_W'(w_pop);
    w_issue = reset && !bus.flush && (w_occ < CNT_W'(DEPTH));
  end

  assign bus.rom_addr     = bus.pc;
  assign bus.pc_increment = w_issue;
  assign bus.instr_valid  = w_valid;
  assign bus.instr        = r_data[r_rd_ptr];
  assign bus.instr_addr   = r_addr[r_rd_ptr];

  // Pointers, occupancy and the in-flight fetch tracker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else if (bus.flush) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= r_inflight_addr;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr <= bus.pc;
      end else begin
        r_inflight_addr <= r_inflight_addr;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // FIFO storage; cleared on reset so the head reads zero while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_addr[i] <= '0;
      end
    end else if (w_push) begin
      r_data[r_wr_ptr] <= bus.rom_data;
      r_addr[r_wr_ptr] <= r_inflight_addr;
    end else begin
      r_data[r_wr_ptr] <= r_data[r_wr_ptr];
      r_addr[r_wr_ptr] <= r_addr[r_wr_ptr];
    end
  end

`ifdef IFETCH_STATS_EN
  logic [15:0] r_bubble;

  // Saturating count of cycles where decode was ready but nothing was valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bubble <= 16'h0000;
    end else if (bus.instr_ready && !w_valid && (r_bubble != 16'hFFFF)) begin
      r_bubble <= r_bubble + 16'h0001;
    end else begin
      r_bubble <= r_bubble;
    end
  end

  assign bubble_cycles = r_bubble;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a PC model and a
// synchronous ROM model whose word at address a is 0x1000 + a.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        pc_load;
  logic [15:0] pc_target;
  int          checks;
  int          failures;

  instruction_fetch_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

`ifdef IFETCH_STATS_EN
  logic [15:0] bubble_cycles;
`endif

  instruction_fetch #(.DEPTH(2), .DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IFETCH_STATS_EN
    ,
    .bubble_cycles (bubble_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model: load has priority over increment.
  always_ff @(posedge clk) begin
    if (pc_load) bus.pc <= pc_target;
    else if (bus.pc_increment) bus.pc <= bus.pc + 16'd1;
  end

  // Synchronous ROM model.
  always_ff @(posedge clk) begin
    bus.rom_data <= 16'h1000 + bus.rom_addr;
  end

  // Advance to just after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Hold reset, preset the PC, then release reset at the start of cycle 0.
  task automatic do_reset(input logic [15:0] start_pc, input logic rdy);
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.instr_ready = rdy;
    pc_load = 1'b1;
    pc_target = start_pc;
    next();
    pc_load = 1'b0;
    next();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.instr_ready = 1'b1;
    pc_load = 1'b1;
    pc_target = 16'h0000;
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
    checks++; if (bus.pc_increment !== 1'b0) begin failures++; $display("FAIL reset_pc_inc: got %b expected 0", bus.pc_increment); end
    next();
    #3;
    checks++; if (bus.instr !== 16'h0000) begin failures++; $display("FAIL reset_instr: got %h expected 0000", bus.instr); end
    checks++; if (bus.instr_addr !== 16'h0000) begin failures++; $display("FAIL reset_instr_addr: got %h expected 0000", bus.instr_addr); end
    checks++; if (bus.rom_addr !== 16'h0000) begin failures++; $display("FAIL reset_rom_addr: got %h expected 0000", bus.rom_addr); end
    checks++; if (bus.pc_increment !== 1'b0) begin failures++; $display("FAIL reset_hold_pc_inc: got %b expected 0", bus.pc_increment); end
    next();
  endtask

  task automatic test_stream();
    logic [15:0] exp_a;
    int          delivered;
    bit          started;
    int          bub_model;
    exp_a = 16'h0000;
    delivered = 0;
    started = 1'b0;
    bub_model = 0;
    do_reset(16'h0000, 1'b1);
    for (int cyc = 0; cyc < 20; cyc++) begin
      #3;
      if (cyc == 0) begin
        checks++; if (bus.pc_increment !== 1'b1) begin failures++; $display("FAIL stream_first_issue: got %b expected 1", bus.pc_increment); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL stream_first_valid: got %b expected 0", bus.instr_valid); end
      end
      if (bus.instr_valid === 1'b1) begin
`ifdef IFETCH_STATS_EN
        if (!started) begin
          checks++; if (bubble_cycles !== 16'(bub_model)) begin failures++; $display("FAIL stream_bubbles: got %0d expected %0d", bubble_cycles, bub_model); end
        end
`endif
        started = 1'b1;
        checks++; if (bus.instr_addr !== exp_a) begin failures++; $display("FAIL stream_addr: got %h expected %h", bus.instr_addr, exp_a); end
        checks++; if (bus.instr !== 16'(16'h1000 + exp_a)) begin failures++; $display("FAIL stream_data: got %h expected %h", bus.instr, 16'(16'h1000 + exp_a)); end
        exp_a = exp_a + 16'd1;
        delivered++;
      end else if (started) begin
        checks++; failures++; $display("FAIL stream_gap: got valid=0 expected 1 at cycle %0d", cyc);
      end
      if (bus.instr_ready && !bus.instr_valid) bub_model++;
      next();
    end
    checks++; if (delivered < 17) begin failures++; $display("FAIL stream_count: got %0d expected at least 17", delivered); end
  endtask

  task automatic test_backpressure();
    int          issues;
    logic [15:0] exp_a;
    issues = 0;
    do_reset(16'h0000, 1'b0);
    for (int cyc = 0; cyc < 6; cyc++) begin
      #3;
      if (bus.pc_increment === 1'b1) issues++;
      next();
    end
    #3;
    checks++; if (issues != 2) begin failures++; $display("FAIL bp_issues: got %0d expected 2", issues); end
    checks++; if (bus.pc !== 16'h0002) begin failures++; $display("FAIL bp_pc: got %h expected 0002", bus.pc); end
    checks++; if (bus.pc_increment !== 1'b0) begin failures++; $display("FAIL bp_pc_inc: got %b expected 0", bus.pc_increment); end
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", bus.instr_valid); end
    checks++; if (bus.instr_addr !== 16'h0000) begin failures++; $display("FAIL bp_head_addr: got %h expected 0000", bus.instr_addr); end
    next();
    bus.instr_ready = 1'b1;
    exp_a = 16'h0000;
    for (int cyc = 0; cyc < 14 && exp_a < 16'd6; cyc++) begin
      #3;
      if (bus.instr_valid === 1'b1) begin
        checks++; if (bus.instr_addr !== exp_a) begin failures++; $display("FAIL bp_addr: got %h expected %h", bus.instr_addr, exp_a); end
        checks++; if (bus.instr !== 16'(16'h1000 + exp_a)) begin failures++; $display("FAIL bp_data: got %h expected %h", bus.instr, 16'(16'h1000 + exp_a)); end
        exp_a = exp_a + 16'd1;
      end
      next();
    end
    checks++; if (exp_a !== 16'd6) begin failures++; $display("FAIL bp_drain: got %0d expected 6", exp_a); end
  endtask

  task automatic test_flush_stream();
    bit          found;
    logic [15:0] exp_a;
    found = 1'b0;
    do_reset(16'h0000, 1'b1);
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      #3;
      if (bus.instr_valid === 1'b1 && bus.instr_addr === 16'h0004) found = 1'b1;
      next();
    end
    checks++; if (!found) begin failures++; $display("FAIL fs_reach: got no addr 4 expected addr 4 within bound"); end
    bus.flush = 1'b1;
    pc_load = 1'b1;
    pc_target = 16'h0040;
    #3;
    checks++; if (bus.instr_addr !== 16'h0005) begin failures++; $display("FAIL fs_head: got %h expected 0005", bus.instr_addr); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL fs_valid_flush: got %b expected 0", bus.instr_valid); end
    checks++; if (bus.pc_increment !== 1'b0) begin failures++; $display("FAIL fs_issue_flush: got %b expected 0", bus.pc_increment); end
    next();
    bus.flush = 1'b0;
    pc_load = 1'b0;
    #3;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL fs_valid_after: got %b expected 0", bus.instr_valid); end
    checks++; if (bus.pc_increment !== 1'b1) begin failures++; $display("FAIL fs_reissue: got %b expected 1", bus.pc_increment); end
    checks++; if (bus.rom_addr !== 16'h0040) begin failures++; $display("FAIL fs_rom_addr: got %h expected 0040", bus.rom_addr); end
    next();
    exp_a = 16'h0040;
    for (int cyc = 0; cyc < 10 && exp_a < 16'h0043; cyc++) begin
      #3;
      if (bus.instr_valid === 1'b1) begin
        checks++; if (bus.instr_addr !== exp_a) begin failures++; $display("FAIL fs_addr: got %h expected %h", bus.instr_addr, exp_a); end
        checks++; if (bus.instr !== 16'(16'h1000 + exp_a)) begin failures++; $display("FAIL fs_data: got %h expected %h", bus.instr, 16'(16'h1000 + exp_a)); end
        exp_a = exp_a + 16'd1;
      end
      next();
    end
    checks++; if (exp_a !== 16'h0043) begin failures++; $display("FAIL fs_resume: got %h expected 0043", exp_a); end
  endtask

  task automatic test_flush_full();
    logic [15:0] exp_a;
    do_reset(16'h0010, 1'b0);
    for (int cyc = 0; cyc < 4; cyc++) next();
    #3;
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL ff_valid: got %b expected 1", bus.instr_valid); end
    checks++; if (bus.instr_addr !== 16'h0010) begin failures++; $display("FAIL ff_head: got %h expected 0010", bus.instr_addr); end
    checks++; if (bus.pc_increment !== 1'b0) begin failures++; $display("FAIL ff_full: got %b expected 0", bus.pc_increment); end
    next();
    bus.instr_ready = 1'b1;
    bus.flush = 1'b1;
    pc_load = 1'b1;
    pc_target = 16'h0080;
    #3;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL ff_valid_flush: got %b expected 0", bus.instr_valid); end
    next();
    bus.flush = 1'b0;
    pc_load = 1'b0;
    #3;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL ff_emptied: got %b expected 0", bus.instr_valid); end
    next();
    exp_a = 16'h0080;
    for (int cyc = 0; cyc < 10 && exp_a < 16'h0082; cyc++) begin
      #3;
      if (bus.instr_valid === 1'b1) begin
        checks++; if (bus.instr_addr !== exp_a) begin failures++; $display("FAIL ff_addr: got %h expected %h", bus.instr_addr, exp_a); end
        checks++; if (bus.instr !== 16'(16'h1000 + exp_a)) begin failures++; $display("FAIL ff_data: got %h expected %h", bus.instr, 16'(16'h1000 + exp_a)); end
        exp_a = exp_a + 16'd1;
      end
      next();
    end
    checks++; if (exp_a !== 16'h0082) begin failures++; $display("FAIL ff_resume: got %h expected 0082", exp_a); end
  endtask

  task automatic test_async_reset();
    logic [15:0] exp_a;
    do_reset(16'h0020, 1'b0);
    for (int cyc = 0; cyc < 3; cyc++) next();
    bus.instr_ready = 1'b1;
    #3;
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL ar_valid_before: got %b expected 1", bus.instr_valid); end
    checks++; if (bus.pc_increment !== 1'b1) begin failures++; $display("FAIL ar_issue_before: got %b expected 1", bus.pc_increment); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL ar_valid_drop: got %b expected 0", bus.instr_valid); end
    checks++; if (bus.pc_increment !== 1'b0) begin failures++; $display("FAIL ar_issue_drop: got %b expected 0", bus.pc_increment); end
    checks++; if (bus.instr_addr !== 16'h0000) begin failures++; $display("FAIL ar_addr_clear: got %h expected 0000", bus.instr_addr); end
    next();
    next();
    checks++; if (bus.pc !== 16'h0022) begin failures++; $display("FAIL ar_pc_hold: got %h expected 0022", bus.pc); end
    reset = 1'b1;
    exp_a = 16'h0022;
    for (int cyc = 0; cyc < 10 && exp_a < 16'h0025; cyc++) begin
      #3;
      if (bus.instr_valid === 1'b1) begin
        checks++; if (bus.instr_addr !== exp_a) begin failures++; $display("FAIL ar_addr: got %h expected %h", bus.instr_addr, exp_a); end
        checks++; if (bus.instr !== 16'(16'h1000 + exp_a)) begin failures++; $display("FAIL ar_data: got %h expected %h", bus.instr, 16'(16'h1000 + exp_a)); end
        exp_a = exp_a + 16'd1;
      end
      next();
    end
    checks++; if (exp_a !== 16'h0025) begin failures++; $display("FAIL ar_restart: got %h expected 0025", exp_a); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a;
    int          n;
    exp_a = 16'hFFFE;
    n = 0;
    do_reset(16'hFFFE, 1'b1);
    for (int cyc = 0; cyc < 10 && n < 3; cyc++) begin
      #3;
      if (bus.instr_valid === 1'b1) begin
        checks++; if (bus.instr_addr !== exp_a) begin failures++; $display("FAIL wrap_addr: got %h expected %h", bus.instr_addr, exp_a); end
        checks++; if (bus.instr !== 16'(16'h1000 + exp_a)) begin failures++; $display("FAIL wrap_data: got %h expected %h", bus.instr, 16'(16'h1000 + exp_a)); end
        exp_a = exp_a + 16'd1;
        n++;
      end
      next();
    end
    checks++; if (n != 3) begin failures++; $display("FAIL wrap_count: got %0d expected 3", n); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_stream();
    test_flush_full();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
